lut_cfg_frac: RTL and testbench

- Parametrised, runtime-reconfigurable K-input LUTRAM primitive for building configurable muxes and logic in the overlay.
- Keeps the single-bit addressed write port (a/d/we) and the read address (dpra) of the existing LUTRAM wrapper.
- Adds three features:
  - a serial configuration loader with a valid/ready handshake;
  - a fracturable mode that gives two (K-1)-input outputs alongside the full K-input output;
  - a reset that restores the parameter mask.
- Sits under the overlay's configuration controller; one instance per physical LUT site.

---
 rtl/lut_cfg_frac.sv | 178 +++++++++++++++++
 tb/tb_lut_cfg_frac.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_cfg_frac.sv
// lut_cfg_frac: runtime-reconfigurable K-input LUTRAM primitive.
//
// The truth table lives in a 2**K-bit mask register. There are two ways to
// change it. One is a single-bit direct write port (a/d/we), which is only
// honoured while the loader is idle. The other is a serial loader that
// accepts the whole mask, bit 0 first, over a valid/ready handshake.
// Reset restores the LUT_MASK parameter.
//
// Reads are fracturable. dpo is the full K-input lookup. dpo_lo and dpo_hi
// are the two (K-1)-input halves, selected by forcing the address MSB to 0
// or 1.
//
// Optional feature (macro LUT_CFG_REG_OUT_EN):
//   defined   - dpo/dpo_lo/dpo_hi are registered (one-cycle latency,
//               reset to 0, load 0 while a serial load is in progress)
//   undefined - the outputs are combinational with zero latency
//
// Parameters:
//   K         number of LUT inputs (2..8)
//   LUT_MASK  reset truth table, [0:2**K-1], bit i = output at address i
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   a, d, we          direct write address / data / enable
//   dpra              read address (LUT inputs)
//   cfg_start         begin a serial load of the full mask
//   cfg_valid         cfg_data carries a valid bit this cycle
//   cfg_data          serial mask bit
//   cfg_ready         loader accepts a bit this cycle
//   cfg_busy          a serial load is in progress
//   cfg_done          one-cycle pulse after the last bit is stored
//   dpo               mask[dpra]
//   dpo_lo            mask[{1'b0, dpra[K-2:0]}]
//   dpo_hi            mask[{1'b1, dpra[K-2:0]}]
module lut_cfg_frac #(
  parameter int K = 6,
  parameter logic [0:2**K-1] LUT_MASK = {2**K{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] a,
  input  logic         d,
  input  logic         we,
  input  logic [K-1:0] dpra,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_data,
  output logic         cfg_ready,
  output logic         cfg_busy,
  output logic         cfg_done,
  output logic         dpo,
  output logic         dpo_lo,
  output logic         dpo_hi
);

  localparam int N = 2**K;
  localparam logic [K-1:0] CntLast = {K{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [K-1:0]     cnt_q, cnt_d;
  logic [0:N-1]     mask_q, mask_d;

  logic             loading;
  logic [K-1:0]     addrLo, addrHi;
  logic             rdFull, rdLo, rdHi;

  // State, counter and truth-table registers. Reset discards any partially
  // loaded mask and returns to the parameter table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= LUT_MASK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state logic and handshake outputs. Direct writes are accepted only
  // in IDLE. A direct write that arrives in the same cycle as cfg_start is
  // still performed. Once LOAD is entered, only accepted serial bits touch
  // the mask. cfg_start is ignored outside IDLE, so a running load cannot
  // be restarted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    cfg_ready = 1'b0;
    cfg_busy  = 1'b0;
    cfg_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (we) begin
          mask_d[a] = d;
        end
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        cfg_ready = 1'b1;
        cfg_busy  = 1'b1;
        if (cfg_valid) begin
          mask_d[cnt_q] = cfg_data;
          if (cnt_q == CntLast) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        cfg_done = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Fracture addressing: the low and high halves share the lower K-1
  // address bits, and the MSB is forced to 0 or 1.
  assign addrLo  = {1'b0, dpra[K-2:0]};
  assign addrHi  = {1'b1, dpra[K-2:0]};
  assign rdFull  = mask_q[dpra];
  assign rdLo    = mask_q[addrLo];
  assign rdHi    = mask_q[addrHi];
  assign loading = (state_q == LOAD);

`ifdef LUT_CFG_REG_OUT_EN
  logic dpo_q, dpoLo_q, dpoHi_q;

  // Registered read path. The registers load zero while a load is in
  // progress, so downstream routing never sees a partially loaded mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      dpo_q   <= 1'b0;
      dpoLo_q <= 1'b0;
      dpoHi_q <= 1'b0;
    end else if (loading) begin
      dpo_q   <= 1'b0;
      dpoLo_q <= 1'b0;
      dpoHi_q <= 1'b0;
    end else begin
      dpo_q   <= rdFull;
      dpoLo_q <= rdLo;
      dpoHi_q <= rdHi;
    end
  end

  assign dpo    = dpo_q;
  assign dpo_lo = dpoLo_q;
  assign dpo_hi = dpoHi_q;
`else
  // Combinational read path. The outputs are held at zero during a load so
  // that a partially loaded mask cannot glitch routing.
  assign dpo    = loading ? 1'b0 : rdFull;
  assign dpo_lo = loading ? 1'b0 : rdLo;
  assign dpo_hi = loading ? 1'b0 : rdHi;
`endif

endmodule

// File: tb/tb_lut_cfg_frac.sv
// tb_lut_cfg_frac: directed self-checking bench for lut_cfg_frac, K = 6.
// The reset table has only bit 5 set. The default build exercises the
// combinational read path. With LUT_CFG_REG_OUT_EN defined, a short
// sequence checks the registered outputs instead.
module tb_lut_cfg_frac;

  localparam int K = 6;
  // Under [0:63] ordering, element 5 sits at vector position 63-5 = 58.
  localparam logic [0:63] TbMask = 64'h0400_0000_0000_0000;

  logic       clk;
  logic       rst;
  logic [5:0] a;
  logic       d;
  logic       we;
  logic [5:0] dpra;
  logic       cfgStart;
  logic       cfgValid;
  logic       cfgData;
  logic       cfgReady;
  logic       cfgBusy;
  logic       cfgDone;
  logic       dpo;
  logic       dpoLo;
  logic       dpoHi;

  int          compared   = 0;
  int          mismatched = 0;
  logic [0:63] model;
  logic [0:63] patOdd;
  logic [0:63] patMod3;

  lut_cfg_frac #(
    .K        (K),
    .LUT_MASK (TbMask)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .d         (d),
    .we        (we),
    .dpra      (dpra),
    .cfg_start (cfgStart),
    .cfg_valid (cfgValid),
    .cfg_data  (cfgData),
    .cfg_ready (cfgReady),
    .cfg_busy  (cfgBusy),
    .cfg_done  (cfgDone),
    .dpo       (dpo),
    .dpo_lo    (dpoLo),
    .dpo_hi    (dpoHi)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Set the read address and let the combinational path settle
  task automatic applyStimulus(input logic [5:0] addr);
    dpra = addr;
    #1;
  endtask

  // Full sweep of all three read ports against the model
  task automatic sweep(input string tag);
    logic [5:0] lo;
    logic [5:0] hi;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(6'(i));
      lo = {1'b0, dpra[4:0]};
      hi = {1'b1, dpra[4:0]};
      checkOutput({tag, "_dpo"},    dpo,   model[i]);
      checkOutput({tag, "_dpoLo"},  dpoLo, model[lo]);
      checkOutput({tag, "_dpoHi"},  dpoHi, model[hi]);
    end
  endtask

  // Serial load of a full mask. stallMod > 0 drops cfg_valid on every
  // stallMod-th cycle. collide keeps we/a=0/d=1 asserted throughout and
  // pulses cfg_start mid-load and in DONE. probe is the read address held
  // during the load and in DONE.
  task automatic loadMask(input logic [0:63] pat, input int stallMod, input bit collide,
                          input logic [5:0] probe);
    int idx;
    int cyc;
    bit v;
    idx = 0;
    cyc = 0;
    dpra = probe;
    cfgStart = 1'b1;
    step();
    cfgStart = 1'b0;
    checkOutput("readyAfterStart", cfgReady, 1'b1);
    while (idx < 64 && cyc < 400) begin
      v = (stallMod == 0) ? 1'b1 : ((cyc % stallMod) != (stallMod - 1));
      cfgValid = v;
      cfgData  = v ? pat[idx] : ~pat[idx];
      if (collide) begin
        we       = 1'b1;
        a        = 6'd0;
        d        = 1'b1;
        cfgStart = (idx == 10 || idx == 30);
      end
      #1;
      checkOutput("busyDuringLoad", cfgBusy, 1'b1);
      checkOutput("dpoZeroDuringLoad", dpo, 1'b0);
      checkOutput("noEarlyDone", cfgDone, 1'b0);
      step();
      if (v) idx++;
      cyc++;
    end
    cfgValid = 1'b0;
    cfgStart = 1'b0;
    checkOutput("loadCompleted", idx == 64, 1'b1);
    checkOutput("donePulse", cfgDone, 1'b1);
    checkOutput("doneNotBusy", cfgBusy, 1'b0);
    checkOutput("doneNotReady", cfgReady, 1'b0);
    checkOutput("doneDrivesNewMask", dpo, pat[probe]);
    if (collide) cfgStart = 1'b1;
    step();
    we       = 1'b0;
    cfgStart = 1'b0;
    checkOutput("doneOneCycle", cfgDone, 1'b0);
    checkOutput("idleAfterDone", cfgBusy, 1'b0);
    model = pat;
  endtask

  initial begin
    rst      = 1'b1;
    a        = '0;
    d        = 1'b0;
    we       = 1'b0;
    dpra     = '0;
    cfgStart = 1'b0;
    cfgValid = 1'b0;
    cfgData  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      patOdd[i]  = (i % 2) == 1;
      patMod3[i] = (i % 3) == 1;
    end
    model = TbMask;
    step();
    step();

`ifdef LUT_CFG_REG_OUT_EN
    rst = 1'b0;
    dpra = 6'd5;
    #1;
    checkOutput("regResetZero", dpo, 1'b0);
    step();
    checkOutput("regDpra5", dpo, 1'b1);
    checkOutput("regDpoLo5", dpoLo, 1'b1);
    dpra = 6'd6;
    #1;
    checkOutput("regHoldOld", dpo, 1'b1);
    step();
    checkOutput("regDpra6", dpo, 1'b0);
    step();
    checkOutput("regDpra6Stable", dpo, 1'b0);
    checkOutput("regIdleNotBusy", cfgBusy, 1'b0);
    checkOutput("regIdleNotDone", cfgDone, 1'b0);
    checkOutput("regIdleNotReady", cfgReady, 1'b0);
    dpra = 6'd5;
    step();
    checkOutput("regBackTo5", dpo, 1'b1);
    checkOutput("regDpoHi5", dpoHi, 1'b0);
`else
    // Reset state
    checkOutput("resetReady", cfgReady, 1'b0);
    checkOutput("resetBusy", cfgBusy, 1'b0);
    checkOutput("resetDone", cfgDone, 1'b0);
    rst = 1'b0;
    applyStimulus(6'd5);
    checkOutput("resetDpo5", dpo, 1'b1);
    checkOutput("resetDpoLo5", dpoLo, 1'b1);
    checkOutput("resetDpoHi5", dpoHi, 1'b0);
    applyStimulus(6'd6);
    checkOutput("resetDpo6", dpo, 1'b0);

    // Direct write of mask[37], with no write-through in the same cycle
    we = 1'b1;
    a  = 6'd37;
    d  = 1'b1;
    applyStimulus(6'd5);
    checkOutput("noWriteThrough", dpoHi, 1'b0);
    step();
    we = 1'b0;
    #1;
    checkOutput("writeDpoHi5", dpoHi, 1'b1);
    checkOutput("writeDpo5Same", dpo, 1'b1);
    applyStimulus(6'd37);
    checkOutput("writeDpo37", dpo, 1'b1);
    model[37] = 1'b1;
    sweep("afterWrite");

    // Serial load, odd bits set, cfg_valid dropped every third cycle
    loadMask(patOdd, 3, 1'b0, 6'd37);
    applyStimulus(6'd7);
    checkOutput("oddDpo7", dpo, 1'b1);
    applyStimulus(6'd8);
    checkOutput("oddDpo8", dpo, 1'b0);

    // Collision load: cfg_start and direct writes during LOAD are ignored
    loadMask(patMod3, 4, 1'b1, 6'd7);
    applyStimulus(6'd0);
    checkOutput("collideMask0", dpo, 1'b0);
    applyStimulus(6'd5);
    checkOutput("collideDpoLo5", dpoLo, 1'b0);
    checkOutput("collideDpoHi5", dpoHi, 1'b1);
    sweep("collide");

    // Reset after 20 accepted bits of a load
    dpra = 6'd5;
    cfgStart = 1'b1;
    step();
    cfgStart = 1'b0;
    cfgValid = 1'b1;
    cfgData  = 1'b1;
    for (int i = 0; i < 20; i++) step();
    cfgValid = 1'b0;
    checkOutput("busyBeforeReset", cfgBusy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midResetBusy", cfgBusy, 1'b0);
    checkOutput("midResetDone", cfgDone, 1'b0);
    checkOutput("midResetReady", cfgReady, 1'b0);
    step();
    checkOutput("midResetNoDone", cfgDone, 1'b0);
    applyStimulus(6'd5);
    checkOutput("midResetDpo5", dpo, 1'b1);
    applyStimulus(6'd1);
    checkOutput("midResetDpo1", dpo, 1'b0);
    applyStimulus(6'd37);
    checkOutput("midResetDpo37", dpo, 1'b0);
    model = TbMask;
    sweep("afterMidReset");

    // Fresh full load after the aborted one
    loadMask(patOdd, 0, 1'b0, 6'd7);
    sweep("reload");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
